// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: operation encoding shared with the downstream multi_counter
package multi_counter_pkg;
    typedef enum logic [2:0] {OP_NOP, OP_INIT, OP_INC, OP_DEC, OP_ADD, OP_QRY} op_t;
endpackage

// File: rtl/multi_counter_arb_if.sv
// multi_counter_arb_if: requester, counter-command and status buses of multi_counter_arb
interface multi_counter_arb_if #(
    parameter int REQ_N      = 4,
    parameter int CNTRS_N    = 256,
    parameter int CNTRS_W    = 32,
    parameter int CNTRS_ID_W = $clog2(CNTRS_N)
);
    import multi_counter_pkg::*;
    logic [REQ_N-1:0]                    req_vld;
    logic [REQ_N-1:0]                    req_rdy;
    logic [REQ_N*CNTRS_ID_W-1:0]         req_id;
    logic [REQ_N*$bits(op_t)-1:0]        req_op;
    logic [REQ_N*CNTRS_W-1:0]            req_dat;
    logic                                cntr_pass;
    logic [CNTRS_ID_W-1:0]               cntr_id;
    op_t                                 cntr_op;
    logic [CNTRS_W-1:0]                  cntr_dat;
    logic                                status_pass_r;
    logic                                status_qry_r;
    logic [CNTRS_ID_W-1:0]               status_id_r;
    logic [CNTRS_W-1:0]                  status_dat_r;
    logic [REQ_N-1:0]                    rsp_vld;
    logic [CNTRS_ID_W-1:0]               rsp_id;
    logic [CNTRS_W-1:0]                  rsp_dat;
    logic                                init_done;
    logic                                err_r;
    modport slave (
        input  req_vld, req_id, req_op, req_dat,
        input  status_pass_r, status_qry_r, status_id_r, status_dat_r,
        output req_rdy, cntr_pass, cntr_id, cntr_op, cntr_dat,
        output rsp_vld, rsp_id, rsp_dat, init_done, err_r
    );
    modport master (
        output req_vld, req_id, req_op, req_dat,
        output status_pass_r, status_qry_r, status_id_r, status_dat_r,
        input  req_rdy, cntr_pass, cntr_id, cntr_op, cntr_dat,
        input  rsp_vld, rsp_id, rsp_dat, init_done, err_r
    );
endinterface

// File: rtl/multi_counter_arb.sv
// multi_counter_arb: round-robin arbiter in front of multi_counter with init sweep
// and tag pipeline that routes query results back to the issuing requester.
module multi_counter_arb
    import multi_counter_pkg::*;
#(
    parameter int REQ_N      = 4,
    parameter int CNTRS_N    = 256,
    parameter int CNTRS_W    = 32,
    parameter int CNTRS_ID_W = $clog2(CNTRS_N),
    parameter int REQ_ID_W   = $clog2(REQ_N),
    parameter int LAT        = 4
) (
    input logic               clk,
    input logic               rst,
    multi_counter_arb_if.slave bus
);
    localparam int OP_W = $bits(op_t);
    localparam int DR_W = $clog2(LAT + 1);
    typedef enum logic [1:0] {INIT, DRAIN, RUN} state_t;
    state_t                state, state_nxt;
    logic [CNTRS_ID_W:0]   sweep;
    logic [DR_W-1:0]       drain;
    logic [REQ_ID_W-1:0]   rr, gnt;
    logic                  found, run, pass, hit, mism, err;
    logic [CNTRS_ID_W-1:0] id, sel_id;
    op_t                   op, sel_op;
    logic [CNTRS_W-1:0]    dat, sel_dat;
    logic [LAT-1:0]        p_vld, p_sw;
    logic [REQ_ID_W-1:0]   p_tag [LAT];
    logic [CNTRS_ID_W-1:0] p_id [LAT];
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < REQ_N; k++)
            if (!found && bus.req_vld[(int'(rr) + k) % REQ_N]) begin
                found = 1'b1;
                gnt   = REQ_ID_W'((int'(rr) + k) % REQ_N);
            end
    end
    assign sel_id  = bus.req_id[int'(gnt)*CNTRS_ID_W +: CNTRS_ID_W];
    assign sel_op  = op_t'(bus.req_op[int'(gnt)*OP_W +: OP_W]);
    assign sel_dat = bus.req_dat[int'(gnt)*CNTRS_W +: CNTRS_W];
    // Everything is forced low while rst is held, regardless of current state.
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        pass      = 1'b0;
        id        = '0;
        op        = OP_NOP;
        dat       = '0;
        case (state)
            INIT: begin
                pass      = 1'b1;
                op        = OP_INIT;
                id        = sweep[CNTRS_ID_W-1:0];
                state_nxt = (sweep == (CNTRS_ID_W+1)'(CNTRS_N - 1)) ? DRAIN : INIT;
            end
            DRAIN: state_nxt = (drain == '0) ? RUN : DRAIN;
            RUN: begin
                run  = 1'b1;
                pass = found && sel_op != OP_NOP;
                id   = found ? sel_id : '0;
                op   = found ? sel_op : OP_NOP;
                dat  = found ? sel_dat : '0;
            end
            default: state_nxt = INIT;
        endcase
        if (rst) begin
            run  = 1'b0;
            pass = 1'b0;
            id   = '0;
            op   = OP_NOP;
            dat  = '0;
        end
    end
    assign bus.req_rdy   = (run && found) ? REQ_N'(1) << gnt : '0;
    assign bus.cntr_pass = pass;
    assign bus.cntr_id   = id;
    assign bus.cntr_op   = op;
    assign bus.cntr_dat  = dat;
    assign bus.init_done = run;
    assign hit  = !rst && bus.status_pass_r && bus.status_qry_r && p_vld[LAT-1] && !p_sw[LAT-1];
    assign mism = (bus.status_pass_r != p_vld[LAT-1]) ||
                  (bus.status_pass_r && bus.status_id_r != p_id[LAT-1]);
    assign bus.rsp_vld = hit ? REQ_N'(1) << p_tag[LAT-1] : '0;
    assign bus.rsp_id  = hit ? bus.status_id_r : '0;
    assign bus.rsp_dat = hit ? bus.status_dat_r : '0;
    assign bus.err_r   = err;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            sweep <= '0;
            drain <= DR_W'(LAT - 1);
            rr    <= '0;
            p_vld <= '0;
            p_sw  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            sweep <= (state == INIT) ? sweep + 1'b1 : sweep;
            drain <= (state == DRAIN) ? drain - 1'b1 : drain;
            rr    <= (run && found) ? ((gnt == REQ_ID_W'(REQ_N - 1)) ? '0 : gnt + 1'b1) : rr;
            for (int k = LAT - 1; k > 0; k--) begin
                p_vld[k] <= p_vld[k-1];
                p_sw[k]  <= p_sw[k-1];
            end
            p_vld[0] <= pass;
            p_sw[0]  <= state == INIT;
            err      <= err | mism;
        end
    end
    always_ff @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            p_tag[k] <= p_tag[k-1];
            p_id[k]  <= p_id[k-1];
        end
        p_tag[0] <= (state == INIT) ? '0 : gnt;
        p_id[0]  <= id;
    end
endmodule

// File: tb/tb_multi_counter_arb.sv
// tb_multi_counter_arb: directed bench with a behavioural multi_counter behind the arbiter
module tb_multi_counter_arb;
    import multi_counter_pkg::*;
    localparam int REQ_N = 4, CNTRS_N = 256, CNTRS_W = 32, IDW = 8, LAT = 4;
    localparam int OW = $bits(op_t);
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0, n_fail = 0;
    logic [CNTRS_W-1:0] mem [CNTRS_N];
    logic [LAT-1:0]     dl_pass, dl_qry;
    logic [IDW-1:0]     dl_id [LAT];
    logic [CNTRS_W-1:0] dl_dat [LAT];
    multi_counter_arb_if #(.REQ_N(REQ_N), .CNTRS_N(CNTRS_N), .CNTRS_W(CNTRS_W)) bus ();
    multi_counter_arb #(.REQ_N(REQ_N), .CNTRS_N(CNTRS_N), .CNTRS_W(CNTRS_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Downstream counter bank with a fixed LAT-cycle status pipe.
    always @(posedge clk) begin
        if (rst) begin
            dl_pass <= '0;
            dl_qry  <= '0;
        end else begin
            for (int k = LAT - 1; k > 0; k--) begin
                dl_id[k]  <= dl_id[k-1];
                dl_dat[k] <= dl_dat[k-1];
            end
            dl_pass   <= {dl_pass[LAT-2:0], bus.cntr_pass};
            dl_qry    <= {dl_qry[LAT-2:0], bus.cntr_pass && bus.cntr_op == OP_QRY};
            dl_id[0]  <= bus.cntr_id;
            dl_dat[0] <= mem[bus.cntr_id];
            if (bus.cntr_pass)
                case (bus.cntr_op)
                    OP_INIT: mem[bus.cntr_id] <= bus.cntr_dat;
                    OP_INC:  mem[bus.cntr_id] <= mem[bus.cntr_id] + 1;
                    OP_DEC:  mem[bus.cntr_id] <= mem[bus.cntr_id] - 1;
                    OP_ADD:  mem[bus.cntr_id] <= mem[bus.cntr_id] + bus.cntr_dat;
                    default: ;
                endcase
        end
    end
    assign bus.status_pass_r = dl_pass[LAT-1];
    assign bus.status_qry_r  = dl_qry[LAT-1];
    assign bus.status_id_r   = dl_id[LAT-1];
    assign bus.status_dat_r  = dl_dat[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [IDW-1:0] id, input op_t op,
                           input logic [CNTRS_W-1:0] dat);
        bus.req_vld[i]                  = v;
        bus.req_id[i*IDW +: IDW]        = id;
        bus.req_op[i*OW +: OW]          = op;
        bus.req_dat[i*CNTRS_W +: CNTRS_W] = dat;
    endtask

    task automatic clr();
        bus.req_vld = '0;
        bus.req_id  = '0;
        bus.req_op  = '0;
        bus.req_dat = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic cmd(input string tag, input logic [3:0] rdy, input logic pass,
                       input logic [IDW-1:0] id, input op_t op, input logic [CNTRS_W-1:0] dat);
        check({tag, ".rdy"}, 64'(bus.req_rdy), 64'(rdy));
        check({tag, ".pass"}, 64'(bus.cntr_pass), 64'(pass));
        if (pass)
            check({tag, ".cmd"}, 64'({bus.cntr_op, bus.cntr_id, bus.cntr_dat}), 64'({op, id, dat}));
    endtask

    task automatic rsp(input string tag, input logic [3:0] v, input logic [IDW-1:0] id,
                       input logic [CNTRS_W-1:0] dat);
        check({tag, ".vld"}, 64'(bus.rsp_vld), 64'(v));
        if (v != 0)
            check({tag, ".rsp"}, 64'({bus.rsp_id, bus.rsp_dat}), 64'({id, dat}));
    endtask

    initial begin
        clr();
        repeat (3) @(posedge clk);
        smp();
        check("rst.pass", 64'(bus.cntr_pass), 64'(0));
        check("rst.rdy", 64'(bus.req_rdy), 64'(0));
        check("rst.rsp", 64'(bus.rsp_vld), 64'(0));
        check("rst.done", 64'(bus.init_done), 64'(0));
        check("rst.err", 64'(bus.err_r), 64'(0));
        // Queries waiting before init completes must not be granted early.
        set_req(1, 1'b1, 8'd10, OP_QRY, 0);
        set_req(3, 1'b1, 8'd20, OP_QRY, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < CNTRS_N; c++) begin
            smp();
            cmd("sweep", 4'b0000, 1'b1, IDW'(c), OP_INIT, 0);
            check("sweep.done", 64'(bus.init_done), 64'(0));
            cyc();
        end
        for (int d = 0; d < LAT; d++) begin
            smp();
            cmd("drain", 4'b0000, 1'b0, 0, OP_NOP, 0);
            check("drain.done", 64'(bus.init_done), 64'(0));
            cyc();
        end
        smp();
        check("run.done", 64'(bus.init_done), 64'(1));
        cmd("first", 4'b0010, 1'b1, 8'd10, OP_QRY, 0);
        cyc();
        set_req(1, 1'b0, 0, OP_NOP, 0);
        smp();
        cmd("second", 4'b1000, 1'b1, 8'd20, OP_QRY, 0);
        cyc();
        clr();
        smp();
        cmd("idle", 4'b0000, 1'b0, 0, OP_NOP, 0);
        rsp("idle", 4'b0000, 0, 0);
        cyc();
        smp();
        rsp("q10.wait", 4'b0000, 0, 0);
        cyc();
        smp();
        rsp("q10", 4'b0010, 8'd10, 0);
        cyc();
        smp();
        rsp("q20", 4'b1000, 8'd20, 0);
        cyc();
        set_req(0, 1'b1, 8'd5, OP_INIT, 7);
        smp();
        cmd("init5", 4'b0001, 1'b1, 8'd5, OP_INIT, 7);
        cyc();
        set_req(0, 1'b1, 8'd5, OP_QRY, 0);
        smp();
        cmd("qry5", 4'b0001, 1'b1, 8'd5, OP_QRY, 0);
        for (int k = 1; k < LAT; k++) begin
            cyc();
            clr();
            smp();
            rsp("qry5.wait", 4'b0000, 0, 0);
        end
        cyc();
        smp();
        rsp("qry5", 4'b0001, 8'd5, 7);
        cyc();
        set_req(3, 1'b1, 8'd0, OP_NOP, 0);
        smp();
        cmd("nop3", 4'b1000, 1'b0, 0, OP_NOP, 0);
        cyc();
        for (int i = 0; i < REQ_N; i++) set_req(i, 1'b1, IDW'(40 + i), OP_INC, 0);
        for (int k = 0; k < 8; k++) begin
            smp();
            cmd("rot", 4'(1 << (k % 4)), 1'b1, IDW'(40 + k % 4), OP_INC, 0);
            cyc();
        end
        clr();
        for (int k = 0; k <= LAT; k++) begin
            smp();
            rsp("rot.drain", 4'b0000, 0, 0);
            cyc();
        end
        set_req(2, 1'b1, 8'd9, OP_INC, 0);
        for (int k = 0; k < 3; k++) begin
            smp();
            cmd("inc9", 4'b0100, 1'b1, 8'd9, OP_INC, 0);
            cyc();
        end
        set_req(2, 1'b1, 8'd9, OP_QRY, 0);
        smp();
        cmd("qry9", 4'b0100, 1'b1, 8'd9, OP_QRY, 0);
        for (int k = 1; k < LAT; k++) begin
            cyc();
            clr();
            smp();
            rsp("qry9.wait", 4'b0000, 0, 0);
        end
        cyc();
        smp();
        rsp("qry9", 4'b0100, 8'd9, 3);
        check("run.err", 64'(bus.err_r), 64'(0));
        cyc();
        rst = 1'b1;
        smp();
        check("rst2.pass", 64'(bus.cntr_pass), 64'(0));
        check("rst2.done", 64'(bus.init_done), 64'(0));
        cyc();
        rst = 1'b0;
        for (int c = 0; c <= 100; c++) begin
            smp();
            cmd("sweep2", 4'b0000, 1'b1, IDW'(c), OP_INIT, 0);
            rsp("sweep2", 4'b0000, 0, 0);
            cyc();
        end
        rst = 1'b1;
        smp();
        check("midrst.pass", 64'(bus.cntr_pass), 64'(0));
        rsp("midrst", 4'b0000, 0, 0);
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            smp();
            cmd("restart", 4'b0000, 1'b1, IDW'(c), OP_INIT, 0);
            rsp("restart", 4'b0000, 0, 0);
            check("restart.err", 64'(bus.err_r), 64'(0));
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_counter_arb.md
Name: multi_counter_arb

Overview:
- Round-robin arbiter and sequencer in front of multi_counter: shares its single command port among REQ_N requesters.
- Tracks which requester owns each in-flight command and routes query results back, one-hot, to that requester.
- After reset, sweeps every counter to zero with OP_INIT before granting any requester.

Parameters:
REQ_N, 4, number of requesters (2..16)
CNTRS_N, 256, number of counters in the downstream multi_counter
CNTRS_W, 32, counter width
CNTRS_ID_W, $clog2(CNTRS_N), counter id width
REQ_ID_W, $clog2(REQ_N), requester tag width
LAT, 4, cycles from cntr_pass to status_pass_r (fixed downstream latency)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_vld  in  REQ_N  per-requester command valid
req_rdy  out  REQ_N  per-requester grant; a transfer occurs when vld & rdy
req_id  in  REQ_N*CNTRS_ID_W  packed counter ids, requester i at slice i
req_op  in  REQ_N*$bits(op_t)  packed multi_counter_pkg::op_t
req_dat  in  REQ_N*CNTRS_W  packed command data
cntr_pass  out  1  command valid to multi_counter
cntr_id  out  CNTRS_ID_W  counter id
cntr_op  out  op_t  operation
cntr_dat  out  CNTRS_W  data
status_pass_r  in  1  from multi_counter
status_qry_r  in  1  from multi_counter
status_id_r  in  CNTRS_ID_W  from multi_counter
status_dat_r  in  CNTRS_W  from multi_counter
rsp_vld  out  REQ_N  one-hot query response strobe
rsp_id  out  CNTRS_ID_W  response counter id
rsp_dat  out  CNTRS_W  response counter value
init_done  out  1  high once the init sweep has drained
err_r  out  1  sticky tag/latency mismatch flag

Behaviour:
- Reset values: FSM=INIT, sweep ptr=0, rr ptr=0, tag pipe valids=0, err_r=0. All outputs are 0 during the reset cycle.
- FSM states:
  - INIT: cntr_pass=1, cntr_op=OP_INIT, cntr_dat=0, cntr_id=sweep ptr. Ptr increments each cycle. After issuing id CNTRS_N-1, go to DRAIN. req_rdy=0.
  - DRAIN: cntr_pass=0 for LAT cycles (down-counter), then go to RUN. req_rdy=0.
  - RUN: arbitration active. init_done=1 in RUN only. RUN is terminal until rst.
- Arbitration (RUN):
  - Search req_vld starting at rr ptr, wrapping modulo REQ_N; the first valid requester i is granted.
  - req_rdy=onehot(i); req_rdy is combinational from req_vld. Requesters must not gate req_vld on req_rdy.
  - On grant: cntr_pass=1, and cntr_id/op/dat come from slice i, combinationally in the same cycle. Next cycle rr ptr=(i+1) mod REQ_N.
  - No valid request: cntr_pass=0, rr ptr holds, cntr_id/op/dat=0.
  - Requester with req_op==OP_NOP: it is still granted and consumed, but cntr_pass=0 for that cycle. No tag is pushed.
  - Throughput: one command per cycle.
- Tag pipeline: LAT-stage shift register of {valid, tag, id}.
  - Stage 1 loads {cntr_pass, i, cntr_id}; INIT commands load valid=1 with tag=0 and a qualifier bit sweep=1.
  - Stage LAT aligns with status_pass_r.
- Response routing:
  - When status_pass_r & status_qry_r & stage LAT valid & !sweep: rsp_vld[tag]=1, rsp_id=status_id_r, rsp_dat=status_dat_r. This is combinational from the status inputs; there is no backpressure and requesters must accept.
  - Otherwise rsp_vld=0.
- err_r is set, and held until rst, when any of these hold:
  - status_pass_r != stage LAT valid
  - status_pass_r=1 and status_id_r != stage LAT id
- Simultaneous events: all requesters valid means strict rotation 0,1,2,3,0… A single persistent requester is granted every cycle.
- Reset mid-operation: in-flight tags are discarded and the sweep restarts at id 0. The downstream valid pipe is reset by the same rst, so no stray responses appear.
- Wrap-around: the sweep ptr width is CNTRS_ID_W+1 so the terminal compare is exact for non-power-of-2 CNTRS_N.

Test Plan:
- Reset then idle → cntr_pass high for exactly 256 cycles with ids 0..255 and OP_INIT dat 0; DRAIN 4 cycles; init_done=1 at cycle 261 after reset release; err_r=0.
- Post-init, req0 issues OP_INIT id 5 dat 7, then a query of id 5 → rsp_vld=4'b0001, rsp_id=5, rsp_dat=7 exactly 4 cycles after the query grant.
- All 4 requesters hold vld for 8 cycles → grants 0,1,2,3,0,1,2,3; one cntr_pass per cycle.
- req2 increments id 9 three times back-to-back, then queries it → a single rsp_vld[2] with rsp_dat=3; no rsp_vld on other lanes.
- A query issued before init_done is not granted (req_rdy=0) until RUN; the first grant goes to the lowest-index valid requester (rr ptr=0).
- rst asserted mid-sweep at id 100 → next cycles restart at id 0; no rsp_vld pulses; err_r stays 0.
